regfile_mp: RTL
===============

REGFILE_MP -- requirements
Module: regfile_mp

Interface
REQ-001 Parameter DATA_W, default 32: register width in bits.
REQ-002 Parameter ADDR_W, default 5: address width; depth DEPTH = 2**ADDR_W entries.
REQ-003 Parameter NRD, default 2: number of read ports, range 1..4.
REQ-004 Port clk  input  1: single clock; all state updates on its rising edge.
REQ-005 Port reset  input  1: synchronous, active-high reset.
REQ-006 Port rd_en  input  NRD: per-port read enable.
REQ-007 Port rd_addr  input  NRD*ADDR_W: port i address at bits [i*ADDR_W +: ADDR_W].
REQ-008 Port rd_data  output  NRD*DATA_W: port i data at bits [i*DATA_W +: DATA_W].
REQ-009 Port wb_we  input  1: write-back enable.
REQ-010 Port wb_waddr  input  ADDR_W: write-back address.
REQ-011 Port wb_wdata  input  DATA_W: write-back data.
REQ-012 Port iss_en  input  1: issue strobe; marks iss_addr as pending.
REQ-013 Port iss_addr  input  ADDR_W: destination register of the issued instruction.
REQ-014 Port rd_busy  output  NRD: per-port pending flag for rd_addr.
REQ-015 Port ready  output  1: high once the initialisation sweep has finished.

Function
REQ-016 FSM states: INIT, RUN; a sweep counter clr_ptr of ADDR_W bits.
REQ-017 In INIT, each edge writes zero to entry clr_ptr and increments clr_ptr; the edge that clears entry DEPTH-1 moves the FSM to RUN.
REQ-018 ready = (state == RUN); ready goes high exactly DEPTH edges after reset deasserts (32 for defaults).
REQ-019 In INIT, wb_we and iss_en are ignored and all rd_data and rd_busy are zero.
REQ-020 In RUN, an edge with wb_we=1 and wb_waddr!=0 writes wb_wdata to the entry at wb_waddr; writes to address 0 are dropped.
REQ-021 Reads are combinational; rd_data[i] is zero if rd_en[i]=0, if rd_addr[i]=0, if reset=1, or if ready=0.
REQ-022 Forwarding: when rd_en[i], rd_addr[i]!=0, wb_we and wb_waddr==rd_addr[i], rd_data[i] = wb_wdata in the same cycle.
REQ-023 Otherwise rd_data[i] = stored entry at rd_addr[i]; every port is independent and all ports may hit the same address.
REQ-024 Scoreboard: DEPTH pending bits; iss_en with iss_addr!=0 sets bit iss_addr; wb_we with wb_waddr!=0 clears bit wb_waddr.
REQ-025 Simultaneous iss_en and wb_we to the same address: the bit ends set (the new producer wins).
REQ-026 rd_busy[i] = pending[rd_addr[i]] & rd_en[i] & ~(wb_we & wb_waddr==rd_addr[i]); address 0 is never busy.
REQ-027 Registered state changes show on outputs one edge later; forwarding and the rd_busy bypass are the only same-cycle paths.

Reset
REQ-028 reset=1 at an edge: state goes to INIT, clr_ptr to 0 and all pending bits to 0.
REQ-029 While reset=1: ready=0, and all rd_data and rd_busy are zero.
REQ-030 Asserting reset in RUN or in the middle of a sweep restarts the full sweep from entry 0 after deassertion.
REQ-031 Storage is not reset directly; only the sweep clears it.

Configuration
REQ-032 Macro REGFILE_MP_SCOREBOARD_EN: when defined, the scoreboard of REQ-024..REQ-026 is built.
REQ-033 Without it, no pending storage exists, iss_en and iss_addr are unused and rd_busy is held at zero; all other behaviour is unchanged.

Verification
REQ-034 Pulse reset for 2 cycles, then count edges -> ready rises after exactly 32 edges; before that, a read of addr 5 with rd_en returns 0 and a wb write to addr 5 is lost.
REQ-035 After ready, write 0xDEADBEEF to r7, then read r7 on both ports next cycle -> both return 0xDEADBEEF; a write of 0x1234 to r0 -> r0 still reads 0.
REQ-036 Same cycle: wb write 0xA5A5A5A5 to r3 while port 1 reads r3 -> port 1 shows 0xA5A5A5A5 that cycle, and port 0 reading r4 is unaffected.
REQ-037 With the macro defined: issue r9 -> rd_busy=1 on a port reading r9 next cycle; wb to r9 -> rd_busy=0 in that same cycle, with data forwarded.
REQ-038 With the macro defined: iss_en and wb_we both to r9 in one cycle -> r9 busy next cycle; without the macro, rd_busy stays 0 throughout.
REQ-039 Write r2=0x55, assert reset mid-run at sweep position 10 and again later -> ready drops, sweep restarts, and after 32 more edges r2 reads 0.

Source files
------------

// File: rtl/regfile_mp.sv
// Multi-read-port register file with zeroing sweep after reset, write-back forwarding
// and an optional pending-write scoreboard (enabled by macro REGFILE_MP_SCOREBOARD_EN).
module regfile_mp #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int NRD    = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [NRD-1:0]        rd_en,
    input  logic [NRD*ADDR_W-1:0] rd_addr,
    output logic [NRD*DATA_W-1:0] rd_data,
    input  logic                  wb_we,
    input  logic [ADDR_W-1:0]     wb_waddr,
    input  logic [DATA_W-1:0]     wb_wdata,
    input  logic                  iss_en,
    input  logic [ADDR_W-1:0]     iss_addr,
    output logic [NRD-1:0]        rd_busy,
    output logic                  ready
);
    localparam int DEPTH = 2**ADDR_W;

    typedef enum logic {INIT, RUN} state_t;

    state_t            state;
    state_t            state_nxt;
    logic [ADDR_W-1:0] clr_ptr;
    logic [DATA_W-1:0] mem [DEPTH];
    logic [ADDR_W-1:0] rd_addr_a [NRD];
    logic              run_ok;
    logic              wb_valid;

    for (genvar g = 0; g < NRD; g++) begin : g_addr
        assign rd_addr_a[g] = rd_addr[g*ADDR_W +: ADDR_W];
    end

    // Outputs are forced quiet while reset is held, even before the clock samples it.
    assign run_ok   = (state == RUN) && !reset;
    assign ready    = run_ok;
    assign wb_valid = wb_we && (wb_waddr != '0);

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= INIT;
            clr_ptr <= '0;
        end else begin
            state <= state_nxt;
            if (state == INIT)
                clr_ptr <= clr_ptr + ADDR_W'(1);
        end
    end

    always_comb begin
        state_nxt = state;
        if (state == INIT && clr_ptr == ADDR_W'(DEPTH-1))
            state_nxt = RUN;
    end

    // Storage has no reset; the sweep is the only way it gets cleared.
    always_ff @(posedge clk) begin
        if (!reset) begin
            if (state == INIT)
                mem[clr_ptr] <= '0;
            else if (wb_valid)
                mem[wb_waddr] <= wb_wdata;
        end
    end

    always_comb begin
        rd_data = '0;
        for (int i = 0; i < NRD; i++) begin
            if (run_ok && rd_en[i] && rd_addr_a[i] != '0) begin
                if (wb_valid && wb_waddr == rd_addr_a[i])
                    rd_data[i*DATA_W +: DATA_W] = wb_wdata;
                else
                    rd_data[i*DATA_W +: DATA_W] = mem[rd_addr_a[i]];
            end
        end
    end

`ifdef REGFILE_MP_SCOREBOARD_EN
    logic [DEPTH-1:0] pending;

    // Set after clear so a same-cycle issue to the written register leaves it pending.
    always_ff @(posedge clk) begin
        if (reset) begin
            pending <= '0;
        end else if (state == RUN) begin
            if (wb_valid)
                pending[wb_waddr] <= 1'b0;
            if (iss_en && iss_addr != '0)
                pending[iss_addr] <= 1'b1;
        end
    end

    always_comb begin
        rd_busy = '0;
        for (int i = 0; i < NRD; i++) begin
            if (run_ok && rd_en[i] && rd_addr_a[i] != '0 && pending[rd_addr_a[i]]
                && !(wb_we && wb_waddr == rd_addr_a[i]))
                rd_busy[i] = 1'b1;
        end
    end
`else
    logic unused_iss;
    assign unused_iss = ^{iss_en, iss_addr};
    assign rd_busy    = '0;
`endif

endmodule
